// File: rtl/comm_pkg.sv
// comm_pkg: shared widths, default sync word and receiver state encoding for the channel link.
package comm_pkg;
  localparam int SAMPLE_W = 9;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;
  typedef enum logic {HUNT, PAYLOAD} rx_state_t;
endpackage

// File: rtl/channel_receiver_if.sv
// channel_receiver_if: sample input and decoded symbol/byte outputs of the channel receiver.
interface channel_receiver_if;
  import comm_pkg::*;
  logic enable;
  logic signed [SAMPLE_W-1:0] rx_in;
  logic sym_valid;
  logic sym_bit;
  logic lock;
  logic [BYTE_W-1:0] data_out;
  logic data_valid;
  logic frame_done;
  modport master(output enable, rx_in, input sym_valid, sym_bit, lock, data_out, data_valid, frame_done);
  modport slave(input enable, rx_in, output sym_valid, sym_bit, lock, data_out, data_valid, frame_done);
endinterface

// File: rtl/integrate_dump.sv
// integrate_dump: sums SPS samples per symbol and decides the bit on the sign of the sum.
module integrate_dump
  import comm_pkg::*;
#(
  parameter int SPS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic                       sym_valid,
  output logic                       sym_bit
);
  localparam int CNT_W = $clog2(SPS);
  localparam int ACC_W = SAMPLE_W + CNT_W;
  logic signed [ACC_W-1:0] acc, sum;
  logic [CNT_W-1:0] cnt;
  logic last;
  always_comb begin
    sum = acc + {{CNT_W{sample[SAMPLE_W-1]}}, sample};
    last = cnt == CNT_W'(SPS - 1);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc <= '0;
      cnt <= '0;
      sym_valid <= 1'b0;
      sym_bit <= 1'b0;
    end else if (!enable) begin
      acc <= '0;
      cnt <= '0;
      sym_valid <= 1'b0;
    end else begin
      sym_valid <= last;
      // a zero sum decides 1
      sym_bit <= last ? !sum[ACC_W-1] : sym_bit;
      acc <= last ? '0 : sum;
      cnt <= last ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/channel_receiver.sv
// channel_receiver: recovers symbols, hunts for the sync word and delivers a fixed-length payload as bytes.
module channel_receiver
  import comm_pkg::*;
#(
  parameter int                SPS           = 8,
  parameter logic [BYTE_W-1:0] SYNC_WORD     = SYNC_DEFAULT,
  parameter int                PAYLOAD_BYTES = 4
) (
  input logic                clk,
  input logic                reset,
  channel_receiver_if.slave  bus
);
  rx_state_t state;
  logic [BYTE_W-1:0] shreg, byte_reg, shreg_nxt, byte_nxt, data_out;
  logic [3:0] hunt_cnt, hunt_nxt;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic lock, data_valid, frame_done, last_byte;
  integrate_dump #(.SPS(SPS)) u_id (
    .clk(clk),
    .reset(reset),
    .enable(bus.enable),
    .sample(bus.rx_in),
    .sym_valid(bus.sym_valid),
    .sym_bit(bus.sym_bit)
  );
  always_comb begin
    shreg_nxt = {shreg[BYTE_W-2:0], bus.sym_bit};
    byte_nxt = {byte_reg[BYTE_W-2:0], bus.sym_bit};
    hunt_nxt = hunt_cnt == 4'd8 ? 4'd8 : hunt_cnt + 4'd1;
    last_byte = byte_cnt == 8'(PAYLOAD_BYTES - 1);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= HUNT;
      shreg <= '0;
      byte_reg <= '0;
      hunt_cnt <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      lock <= 1'b0;
      data_out <= '0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      if (!bus.enable) begin
        state <= HUNT;
        shreg <= '0;
        hunt_cnt <= '0;
        bit_cnt <= '0;
        byte_cnt <= '0;
        lock <= 1'b0;
      end else if (bus.sym_valid && state == HUNT) begin
        shreg <= shreg_nxt;
        hunt_cnt <= hunt_nxt;
        // hunt_cnt gate keeps the cleared shreg from matching an all-zero sync word
        if (hunt_nxt == 4'd8 && shreg_nxt == SYNC_WORD) begin
          state <= PAYLOAD;
          lock <= 1'b1;
          bit_cnt <= '0;
          byte_cnt <= '0;
        end
      end else if (bus.sym_valid) begin
        byte_reg <= byte_nxt;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          data_out <= byte_nxt;
          data_valid <= 1'b1;
          byte_cnt <= byte_cnt + 8'd1;
          if (last_byte) begin
            frame_done <= 1'b1;
            lock <= 1'b0;
            state <= HUNT;
            shreg <= '0;
            hunt_cnt <= '0;
          end
        end
      end
    end
  assign bus.lock = lock;
  assign bus.data_out = data_out;
  assign bus.data_valid = data_valid;
  assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_channel_receiver.sv
// tb_channel_receiver: directed frames with hand-computed bytes, timing and reset checks.
module tb_channel_receiver;
  logic clk = 1'b0;
  logic reset;
  int n_vec = 0, n_err = 0;
  int ncyc = 0, sv_cnt = 0, sv_last = 0, fd_cnt = 0;
  int lock_rise_cyc = 0, lock_rise_sv = 0, lock_rise_svcyc = 0;
  logic fd_ok = 1'b0, lock_q = 1'b0;
  logic [7:0] dq[$];
  int dc[$];
  int noise[10] = '{0, 1, 3, 7, 15, -1, -2, -4, -8, -16};
  int ni = 0;
  channel_receiver_if bus();
  channel_receiver #(.SPS(4), .SYNC_WORD(8'hA5), .PAYLOAD_BYTES(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    ncyc++;
    if (bus.sym_valid) begin
      sv_cnt++;
      sv_last = ncyc;
    end
    if (bus.lock && !lock_q) begin
      lock_rise_cyc = ncyc;
      lock_rise_sv = sv_cnt;
      lock_rise_svcyc = sv_last;
    end
    lock_q = bus.lock;
    if (bus.data_valid) begin
      dq.push_back(bus.data_out);
      dc.push_back(ncyc);
    end
    if (bus.frame_done) begin
      fd_cnt++;
      fd_ok = bus.data_valid && !bus.lock;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input int v);
    @(negedge clk);
    bus.enable = 1'b1;
    bus.rx_in = 9'(v);
  endtask
  task automatic send_bit(input logic b, input logic noisy);
    int v;
    for (int i = 0; i < 4; i++) begin
      v = b ? (noisy ? 20 : 100) : (noisy ? -20 : -100);
      if (noisy) begin
        v += noise[ni];
        ni = (ni + 1) % 10;
      end
      drive(v);
    end
  endtask
  task automatic send_byte(input logic [7:0] d, input logic noisy);
    for (int i = 7; i >= 0; i--) send_bit(d[i], noisy);
  endtask
  task automatic quiesce();
    repeat (3) @(negedge clk);
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic chk_frame(input string tag, input int db, input int fb, input logic [7:0] b0, input logic [7:0] b1);
    chk({tag, "_n"}, dq.size() - db, 2);
    chk({tag, "_b0"}, dq.size() > db ? 32'(dq[db]) : 32'hdead, 32'(b0));
    chk({tag, "_b1"}, dq.size() > db + 1 ? 32'(dq[db+1]) : 32'hdead, 32'(b1));
    chk({tag, "_gap"}, dq.size() > db + 1 ? dc[db+1] - dc[db] : 0, 32);
    chk({tag, "_fd"}, fd_cnt - fb, 1);
    chk({tag, "_fdok"}, 32'(fd_ok), 1);
  endtask
  initial begin
    int db, fb, sb;
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.rx_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {bus.sym_valid, bus.sym_bit, bus.lock, bus.data_out, bus.data_valid, bus.frame_done}, 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_nosym", sv_cnt, 0);
    drive(1); drive(-1); drive(2); drive(-2);
    @(negedge clk);
    chk("zero_sv", 32'(bus.sym_valid), 1);
    chk("zero_bit", 32'(bus.sym_bit), 1);
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    // clean frame
    db = dq.size(); fb = fd_cnt; sb = sv_cnt;
    send_byte(8'hA5, 0); send_byte(8'h3C, 0); send_byte(8'hC3, 0);
    quiesce();
    chk("clean_lock_sv", lock_rise_sv - sb, 8);
    chk("clean_lock_dly", lock_rise_cyc - lock_rise_svcyc, 1);
    chk_frame("clean", db, fb, 8'h3C, 8'hC3);
    // noisy frame
    db = dq.size(); fb = fd_cnt; ni = 0;
    send_byte(8'hA5, 1); send_byte(8'h3C, 1); send_byte(8'hC3, 1);
    quiesce();
    chk_frame("noisy", db, fb, 8'h3C, 8'hC3);
    // misaligned sync
    db = dq.size(); fb = fd_cnt; sb = sv_cnt;
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
    send_byte(8'hA5, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    quiesce();
    chk("mis_lock_sv", lock_rise_sv - sb, 11);
    chk_frame("mis", db, fb, 8'h11, 8'h22);
    // abort mid-payload
    db = dq.size(); fb = fd_cnt;
    send_byte(8'hA5, 0);
    repeat (4) send_bit(1, 0);
    repeat (2) @(negedge clk);
    chk("abort_pre_lock", 32'(bus.lock), 1);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("abort_lock", 32'(bus.lock), 0);
    repeat (2) @(negedge clk);
    send_byte(8'hA5, 0); send_byte(8'h5A, 0); send_byte(8'h0F, 0);
    quiesce();
    chk_frame("abort", db, fb, 8'h5A, 8'h0F);
    // back-to-back frames
    db = dq.size(); fb = fd_cnt;
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    quiesce();
    chk("b2b_n", dq.size() - db, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("b2b_b%0d", i), dq.size() > db + i ? 32'(dq[db+i]) : 32'hdead, i + 1);
    chk("b2b_fd", fd_cnt - fb, 2);
    // asynchronous reset mid-frame
    send_byte(8'hA5, 0);
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(0, 0);
    repeat (2) @(negedge clk);
    chk("rstm_pre_lock", 32'(bus.lock), 1);
    chk("rstm_pre_data", 32'(bus.data_out), 32'h04);
    #2 reset = 1'b0;
    #1 chk("rstm_outs", {bus.sym_valid, bus.sym_bit, bus.lock, bus.data_out, bus.data_valid, bus.frame_done}, 0);
    @(negedge clk);
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    sb = sv_cnt;
    repeat (10) @(negedge clk);
    chk("rstm_nosym", sv_cnt - sb, 0);
    chk("rstm_data", 32'(bus.data_out), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
